// File: rtl/gelato_simt_stack_if.sv
// gelato_simt_stack_if: control bus from decode into the SIMT reconvergence
// stack. It carries the kernel-launch fields and the per-instruction update.
//   master : decode side; drives every signal
//   slave  : stack side; samples every signal
// Fields:
//   init_valid/init_pc/init_workers      kernel launch (entry PC, thread count)
//   upd_valid/upd_stall/upd_warp/upd_op   update qualifiers, target warp, opcode
//   upd_pc/upd_target/upd_taken/upd_rpc   next PC, branch target, taken bits,
//                                         reconvergence PC
interface gelato_simt_stack_if #(
  parameter int WARP_NUM   = 4,
  parameter int THREAD_NUM = 32,
  parameter int PC_WIDTH   = 32
);
  localparam int WW = $clog2(WARP_NUM);
  localparam int TW = $clog2(THREAD_NUM);

  logic                  init_valid;
  logic [PC_WIDTH-1:0]   init_pc;
  logic [WW+TW:0]        init_workers;
  logic                  upd_valid;
  logic                  upd_stall;
  logic [WW-1:0]         upd_warp;
  logic [1:0]            upd_op;
  logic [PC_WIDTH-1:0]   upd_pc;
  logic [PC_WIDTH-1:0]   upd_target;
  logic [THREAD_NUM-1:0] upd_taken;
  logic [PC_WIDTH-1:0]   upd_rpc;

  modport master (
    output init_valid, init_pc, init_workers,
    output upd_valid, upd_stall, upd_warp, upd_op,
    output upd_pc, upd_target, upd_taken, upd_rpc
  );

  modport slave (
    input init_valid, init_pc, init_workers,
    input upd_valid, upd_stall, upd_warp, upd_op,
    input upd_pc, upd_target, upd_taken, upd_rpc
  );
endinterface

// File: rtl/gelato_simt_stack.sv
// gelato_simt_stack: per-warp SIMT reconvergence stack for fetch.
// Each warp keeps a stack of {pc, rpc, mask} entries. Decode sends one
// control update per cycle (ADVANCE, BRANCH or EXIT) to one warp. A divergent
// branch pushes the two sides. Reaching the reconvergence PC pops the stack.
// An exit strips the exiting threads from the whole stack.
// Ports:
//   clk, rst       clock; synchronous active-high reset (wins over rdy)
//   rdy            global enable; all state holds while low
//   ctrl           launch + update bus (slave side)
//   warp_valid     per-warp "has live threads"
//   warp_pc        per-warp top-of-stack PC, warp i at [i*PC_WIDTH +: PC_WIDTH]
//   warp_mask      per-warp top-of-stack active mask
//   warp_depth     per-warp stack pointer
//   warp_overflow  per-warp sticky divergence-overflow flag

// One warp's stack. It acts only when its upd strobe or init_valid is set.
module gelato_simt_warp #(
  parameter int THREAD_NUM = 32,
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 32,
  parameter int SW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  init_valid,
  input  logic [PC_WIDTH-1:0]   init_pc,
  input  logic [THREAD_NUM-1:0] init_mask,
  input  logic                  upd,
  input  logic [1:0]            op,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [PC_WIDTH-1:0]   target,
  input  logic [THREAD_NUM-1:0] taken,
  input  logic [PC_WIDTH-1:0]   rpc,
  output logic [PC_WIDTH-1:0]   top_pc,
  output logic [THREAD_NUM-1:0] top_mask,
  output logic [SW-1:0]         depth,
  output logic                  live,
  output logic                  ovf
);
  logic [DEPTH-1:0][PC_WIDTH-1:0]   e_pc;
  logic [DEPTH-1:0][PC_WIDTH-1:0]   e_rpc;
  logic [DEPTH-1:0][THREAD_NUM-1:0] e_mask;
  logic [SW-1:0]                    sp;
  logic [SW-1:0]                    sp1, sp2;
  logic [PC_WIDTH-1:0]              top_rpc;
  logic [THREAD_NUM-1:0]            m, t;
  logic                             ovf_hit;

  always_comb begin
    sp1     = sp + SW'(1);
    sp2     = sp + SW'(2);
    top_rpc = e_rpc[sp];
    m       = e_mask[sp];
    t       = taken & m;
    // A divergent push needs two free slots above the current top.
    ovf_hit = (int'(sp) + 2) > (DEPTH - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_pc   <= '0;
      e_rpc  <= '0;
      e_mask <= '0;
      sp     <= '0;
      live   <= 1'b0;
      ovf    <= 1'b0;
    end else if (rdy) begin
      if (init_valid) begin
        sp        <= '0;
        ovf       <= 1'b0;
        live      <= |init_mask;
        e_pc[0]   <= init_pc;
        e_rpc[0]  <= '1;
        e_mask[0] <= init_mask;
      end else if (upd) begin
        case (op)
          2'd0: begin
            // Reconvergence: the entry below already holds rpc as its pc.
            if (sp != '0 && pc == top_rpc) sp <= sp - SW'(1);
            else                           e_pc[sp] <= pc;
          end
          2'd1: begin
            if (t == m)           e_pc[sp] <= target;
            else if (t == '0)     e_pc[sp] <= pc;
            else if (ovf_hit)     ovf <= 1'b1;
            else begin
              // Not-taken side sits below the taken side, so it runs second.
              e_pc[sp]    <= rpc;
              e_pc[sp1]   <= pc;
              e_rpc[sp1]  <= rpc;
              e_mask[sp1] <= m & ~t;
              e_pc[sp2]   <= target;
              e_rpc[sp2]  <= rpc;
              e_mask[sp2] <= t;
              sp          <= sp2;
            end
          end
          2'd2: begin
            for (int i = 0; i < DEPTH; i++)
              if (i <= int'(sp)) e_mask[i] <= e_mask[i] & ~m;
            if (sp != '0) sp <= sp - SW'(1);
            else          live <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign top_pc   = e_pc[sp];
  assign top_mask = e_mask[sp];
  assign depth    = sp;
endmodule

module gelato_simt_stack #(
  parameter int WARP_NUM   = 4,
  parameter int THREAD_NUM = 32,
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 32,
  localparam int WW = $clog2(WARP_NUM),
  localparam int SW = $clog2(DEPTH),
  localparam int TW = $clog2(THREAD_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  gelato_simt_stack_if.slave             ctrl,
  output logic [WARP_NUM-1:0]            warp_valid,
  output logic [WARP_NUM*PC_WIDTH-1:0]   warp_pc,
  output logic [WARP_NUM*THREAD_NUM-1:0] warp_mask,
  output logic [WARP_NUM*SW-1:0]         warp_depth,
  output logic [WARP_NUM-1:0]            warp_overflow
);
  logic [WW+TW:0]                       workers;
  logic [WW-1:0]                        q;
  logic [TW-1:0]                        r;
  logic                                 all_full;
  logic [THREAD_NUM-1:0]                therm;
  logic [WARP_NUM-1:0][THREAD_NUM-1:0]  init_mask;
  logic [WARP_NUM-1:0]                  upd;
  logic                                 upd_ok;

  // Launch split: q full warps, then one partial warp with r threads.
  always_comb begin
    workers  = ctrl.init_workers;
    q        = workers[WW+TW-1:TW];
    r        = workers[TW-1:0];
    all_full = int'(workers) >= WARP_NUM * THREAD_NUM;
    therm    = '0;
    for (int j = 0; j < THREAD_NUM; j++) therm[j] = (j < int'(r));
    for (int i = 0; i < WARP_NUM; i++) begin
      if (all_full || int'(q) > i) init_mask[i] = '1;
      else if (int'(q) == i)       init_mask[i] = therm;
      else                         init_mask[i] = '0;
    end
  end

  assign upd_ok = ctrl.upd_valid & ~ctrl.upd_stall;

  for (genvar i = 0; i < WARP_NUM; i++) begin : g_warp
    // Updates aimed at a warp with no live threads are dropped.
    assign upd[i] = upd_ok & (ctrl.upd_warp == WW'(i)) & warp_valid[i];

    gelato_simt_warp #(
      .THREAD_NUM(THREAD_NUM), .DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .SW(SW)
    ) u_warp (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .init_valid(ctrl.init_valid),
      .init_pc   (ctrl.init_pc),
      .init_mask (init_mask[i]),
      .upd       (upd[i]),
      .op        (ctrl.upd_op),
      .pc        (ctrl.upd_pc),
      .target    (ctrl.upd_target),
      .taken     (ctrl.upd_taken),
      .rpc       (ctrl.upd_rpc),
      .top_pc    (warp_pc[i*PC_WIDTH +: PC_WIDTH]),
      .top_mask  (warp_mask[i*THREAD_NUM +: THREAD_NUM]),
      .depth     (warp_depth[i*SW +: SW]),
      .live      (warp_valid[i]),
      .ovf       (warp_overflow[i])
    );
  end
endmodule
